opa_fwd_stage: RTL

//  Registered ALU operand-A stage for the RISC-V pipeline; sits between decode and the EX ALU.

---
 rtl/opa_fwd_stage_pkg.sv | 17 +
 rtl/opa_fwd_stage_fwd_prio_sel.sv | 43 ++++
 rtl/opa_fwd_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/opa_fwd_stage_pkg.sv
// Shared definitions for the ALU operand-A forwarding stage: operand-select
// codes and default datapath widths.
package opa_fwd_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 5;
  localparam int NFWD_DEF = 2;
  localparam int CNTW_DEF = 16;

  typedef enum logic [1:0] {
    A_SEL_RS1  = 2'b00,
    A_SEL_PC   = 2'b01,
    A_SEL_ZERO = 2'b10,
    A_SEL_RSVD = 2'b11
  } a_sel_e;

endpackage

// File: rtl/opa_fwd_stage_fwd_prio_sel.sv
// Priority forwarding match over NFWD in-flight writers; the lowest index
// (youngest) match wins. x0 never matches.
module fwd_prio_sel #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int NFWD = 2
) (
  input  logic [REGW-1:0]      rs1_addr,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic [NFWD*REGW-1:0] fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic [NFWD-1:0]      win_onehot,
  output logic [XLEN-1:0]      win_data,
  output logic                 win_pending,
  output logic                 win_found
);

  logic [NFWD-1:0] match;
  logic [XLEN-1:0] masked_data [NFWD];

  generate
    for (genvar gi = 0; gi < NFWD; gi++) begin : g_match
      assign match[gi] = fwd_valid[gi]
                       & (fwd_addr[gi*REGW +: REGW] == rs1_addr)
                       & (rs1_addr != '0);
      assign masked_data[gi] = {XLEN{win_onehot[gi]}} & fwd_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Isolate the lowest set bit: youngest source shadows older ones.
  assign win_onehot  = match & (~match + NFWD'(1));
  assign win_found   = |match;
  assign win_pending = |(win_onehot & fwd_pending);

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NFWD; i++) begin
      win_data = win_data | masked_data[i];
    end
  end

endmodule

// File: rtl/opa_fwd_stage.sv
// Registered operand-A stage: selects rs1/PC/zero with rs1 forwarding, stalls
// decode on a pending (load-use) forward, and counts hazard stall cycles.
module opa_fwd_stage
  import opa_fwd_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF,
  parameter int NFWD = NFWD_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_rs1_data,
  input  logic [REGW-1:0]      in_rs1_addr,
  input  logic [1:0]           in_a_sel,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic [NFWD*REGW-1:0] fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_opa,
  output logic [NFWD-1:0]      out_fwd_src,
  output logic [CNTW-1:0]      stall_cnt
);

  logic [NFWD-1:0] win_onehot;
  logic [XLEN-1:0] win_data;
  logic            win_pending;
  logic            win_found;

  fwd_prio_sel #(
    .XLEN(XLEN),
    .REGW(REGW),
    .NFWD(NFWD)
  ) u_fwd_prio_sel (
    .rs1_addr   (in_rs1_addr),
    .fwd_valid  (fwd_valid),
    .fwd_pending(fwd_pending),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data),
    .win_onehot (win_onehot),
    .win_data   (win_data),
    .win_pending(win_pending),
    .win_found  (win_found)
  );

  logic            valid_q, valid_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [NFWD-1:0] src_q, src_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            sel_rs1;
  logic            hazard;
  logic            capture;
  logic [XLEN-1:0] opa_sel;
  logic [NFWD-1:0] src_sel;

  assign sel_rs1  = (in_a_sel == A_SEL_RS1);
  // win_pending already implies a winner exists.
  assign hazard   = in_valid & sel_rs1 & win_pending;
  assign in_ready = ~hazard & ~flush & (~valid_q | out_ready);
  assign capture  = in_valid & in_ready;

  always_comb begin
    opa_sel = '0;
    src_sel = '0;
    case (in_a_sel)
      A_SEL_RS1: begin
        opa_sel = win_found ? win_data : in_rs1_data;
        src_sel = win_onehot;
      end
      A_SEL_PC: opa_sel = in_pc;
      default:  opa_sel = '0;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    opa_d   = opa_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      opa_d   = opa_sel;
      src_d   = src_sel;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (hazard && !flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      opa_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      opa_q   <= opa_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_opa     = opa_q;
  assign out_fwd_src = src_q;
  assign stall_cnt   = cnt_q;

endmodule
